// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM link (multiplexer and demultiplexer).
// Optional feature macro: TDM_DEMUX2_ERRCNT_EN (builds the sync-error counter).
package tdm_pkg;

    // Sample width used by both ends of the link unless overridden.
    localparam int unsigned WIDTH_DEFAULT = 1;

    // Sync-error counter geometry.
    localparam int unsigned ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'd255;

    // Slot-alignment states of the receiver.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_A = 2'd1,
        EXP_B = 2'd2
    } state_e;

endpackage

// File: rtl/tdm_demux2_if.sv
// Shared-link input and per-channel output bundle of tdm_demux2.
// master: link driver / consumer side; slave: the demultiplexer.
interface tdm_demux2_if #(
    parameter int unsigned WIDTH = tdm_pkg::WIDTH_DEFAULT
);
    logic [WIDTH-1:0]             D;
    logic                         Valid;
    logic                         Sync;
    logic [WIDTH-1:0]             A;
    logic [WIDTH-1:0]             B;
    logic                         AValid;
    logic                         BValid;
    logic                         Locked;
    logic [tdm_pkg::ERRCNT_W-1:0] ErrCnt;

    modport master (
        output D, Valid, Sync,
        input  A, B, AValid, BValid, Locked, ErrCnt
    );

    modport slave (
        input  D, Valid, Sync,
        output A, B, AValid, BValid, Locked, ErrCnt
    );
endinterface

// File: rtl/tdm_slot_fsm.sv
// Slot-alignment tracker: decodes Valid/Sync against the current slot
// expectation, produces channel load enables and the sync-error count.
// ErrCnt register exists only when TDM_DEMUX2_ERRCNT_EN is defined.
module tdm_slot_fsm
    import tdm_pkg::*;
(
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                valid,
    input  logic                sync,
    output logic                ld_a_c,
    output logic                ld_b_c,
    output logic                err_inc_c,
    output logic                locked,
    output logic [ERRCNT_W-1:0] err_cnt
);

    state_e state;

    // A sync-flagged sample always belongs to channel A, whatever the state.
    assign ld_a_c = valid & sync;

    // A non-sync sample is channel B only when B is the expected slot.
    assign ld_b_c = valid & ~sync & (state == EXP_B);

    // Missing B slot (sync while expecting B) or sync lost (no sync while expecting A).
    assign err_inc_c = valid & (((state == EXP_B) & sync) | ((state == EXP_A) & ~sync));

    // Slot state and Locked flag advance only on valid samples.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= HUNT;
            locked <= 1'b0;
        end else if (valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        state  <= EXP_B;
                        locked <= 1'b1;
                    end
                end
                EXP_B: begin
                    if (!sync) begin
                        state <= EXP_A;
                    end
                end
                EXP_A: begin
                    if (sync) begin
                        state <= EXP_B;
                    end else begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX2_ERRCNT_EN
    // Saturating sync-error counter; cleared only by reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_cnt <= '0;
        end else if (err_inc_c && (err_cnt != ERRCNT_MAX)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: routes interleaved A/B samples from the
// shared link into per-channel hold registers with one-cycle strobes.
// Optional feature macro: TDM_DEMUX2_ERRCNT_EN (sync-error counter).
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic         Clock,
    input  logic         Resetn,
    tdm_demux2_if.slave  bus
);

    logic                ld_a;
    logic                ld_b;
    logic                err_inc_unused;
    logic                locked;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                a_valid_q;
    logic                b_valid_q;

    tdm_slot_fsm u_slot_fsm (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .valid     (bus.Valid),
        .sync      (bus.Sync),
        .ld_a_c    (ld_a),
        .ld_b_c    (ld_b),
        .err_inc_c (err_inc_unused),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    // Channel hold registers load on their enable and otherwise keep the last sample.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ld_a) begin
                a_q <= bus.D;
            end
            if (ld_b) begin
                b_q <= bus.D;
            end
        end
    end

    // One-cycle update strobes; the enables are mutually exclusive by construction.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= ld_a;
            b_valid_q <= ld_b;
        end
    end

    assign bus.A      = a_q;
    assign bus.B      = b_q;
    assign bus.AValid = a_valid_q;
    assign bus.BValid = b_valid_q;
    assign bus.Locked = locked;
    assign bus.ErrCnt = err_cnt;

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2 against a slot-sequence reference model.
module tb_tdm_demux2;
    localparam int unsigned W = 8;

    logic Clock;
    logic Resetn;

    tdm_demux2_if #(.WIDTH(W)) bus ();

    tdm_demux2 #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remembers which channel was accepted last (0 none, 1 A, 2 B).
    int         last_ch;
    logic [W-1:0] m_a, m_b;
    logic       m_av, m_bv, m_lock;
    int         m_err;

    function automatic logic [7:0] exp_errcnt();
`ifdef TDM_DEMUX2_ERRCNT_EN
        return (m_err > 255) ? 8'd255 : 8'(m_err);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        last_ch = 0; m_a = '0; m_b = '0; m_av = 0; m_bv = 0; m_lock = 0; m_err = 0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
        m_av = 0; m_bv = 0;
        if (v) begin
            if (s) begin
                if (last_ch == 1) m_err++;
                m_a = d; m_av = 1; last_ch = 1;
            end else if (last_ch == 1) begin
                m_b = d; m_bv = 1; last_ch = 2;
            end else if (last_ch == 2) begin
                m_err++; last_ch = 0;
            end
        end
        m_lock = (last_ch != 0);
    endtask

    // Drive one cycle of link input and advance the model past the edge.
    task automatic send(input logic v, input logic s, input logic [W-1:0] d);
        bus.Valid = v; bus.Sync = s; bus.D = d;
        @(posedge Clock); #1;
        model_step(v, s, d);
    endtask

    task automatic apply_reset();
        Resetn = 1'b0; bus.Valid = 0; bus.Sync = 0; bus.D = '0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        Resetn = 1'b0; bus.Valid = 0; bus.Sync = 0; bus.D = '0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !== 27'd0) begin
            n_err++;
            $display("FAIL reset: got A=%h B=%h av=%b bv=%b lk=%b ec=%0d want all 0",
                     bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt);
        end
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_aligned();
        logic [W-1:0] ds [3] = '{8'd3, 8'd5, 8'd9};
        logic         ss [3] = '{1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, ss[i], ds[i]);
            n_cmp++;
            if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !==
                {m_a, m_b, m_av, m_bv, m_lock, exp_errcnt()}) begin
                n_err++;
                $display("FAIL aligned[%0d]: got A=%h B=%h av=%b bv=%b lk=%b ec=%0d want A=%h B=%h av=%b bv=%b lk=%b ec=%0d",
                         i, bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt,
                         m_a, m_b, m_av, m_bv, m_lock, exp_errcnt());
            end
        end
        n_cmp++;
        if ({bus.A, bus.B, bus.Locked, bus.ErrCnt} !== {8'd9, 8'd5, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL aligned_final: got A=%0d B=%0d lk=%b ec=%0d want A=9 B=5 lk=1 ec=0",
                     bus.A, bus.B, bus.Locked, bus.ErrCnt);
        end
    endtask

    task automatic test_hunt_discard();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 8'd7);
            n_cmp++;
            if ({bus.AValid, bus.BValid, bus.Locked, bus.A, bus.B} !== {3'b000, 8'd0, 8'd0}) begin
                n_err++;
                $display("FAIL hunt_discard[%0d]: got av=%b bv=%b lk=%b A=%h B=%h want 0 0 0 0 0",
                         i, bus.AValid, bus.BValid, bus.Locked, bus.A, bus.B);
            end
        end
        send(1'b1, 1'b1, 8'd2);
        n_cmp++;
        if ({bus.A, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !== {8'd2, 3'b101, 8'd0}) begin
            n_err++;
            $display("FAIL hunt_lock: got A=%0d av=%b bv=%b lk=%b ec=%0d want A=2 av=1 bv=0 lk=1 ec=0",
                     bus.A, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt);
        end
    endtask

    task automatic test_missing_b();
        apply_reset();
        send(1'b1, 1'b1, 8'd1);
        send(1'b1, 1'b1, 8'd6);
        n_cmp++;
        if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !==
            {m_a, m_b, m_av, m_bv, m_lock, exp_errcnt()}) begin
            n_err++;
            $display("FAIL missing_b: got A=%0d B=%0d av=%b bv=%b lk=%b ec=%0d want A=%0d B=%0d av=%b bv=%b lk=%b ec=%0d",
                     bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt,
                     m_a, m_b, m_av, m_bv, m_lock, exp_errcnt());
        end
        // Still expecting B: a non-sync sample must land in B.
        send(1'b1, 1'b0, 8'd4);
        n_cmp++;
        if ({bus.B, bus.BValid, bus.AValid} !== {8'd4, 2'b10}) begin
            n_err++;
            $display("FAIL missing_b_then_b: got B=%0d bv=%b av=%b want B=4 bv=1 av=0",
                     bus.B, bus.BValid, bus.AValid);
        end
    endtask

    task automatic test_sync_loss();
        logic [W-1:0] ds [4] = '{8'd1, 8'd4, 8'd8, 8'd3};
        logic         ss [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, ss[i], ds[i]);
            n_cmp++;
            if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !==
                {m_a, m_b, m_av, m_bv, m_lock, exp_errcnt()}) begin
                n_err++;
                $display("FAIL sync_loss[%0d]: got A=%h B=%h av=%b bv=%b lk=%b ec=%0d want A=%h B=%h av=%b bv=%b lk=%b ec=%0d",
                         i, bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt,
                         m_a, m_b, m_av, m_bv, m_lock, exp_errcnt());
            end
        end
    endtask

    task automatic test_random();
        logic v, s;
        logic [W-1:0] d;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0) ? ~(last_ch == 1) : ($urandom_range(0, 1) == 1);
            d = W'($urandom);
            send(v, s, d);
            n_cmp++;
            if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !==
                {m_a, m_b, m_av, m_bv, m_lock, exp_errcnt()}) begin
                n_err++;
                $display("FAIL random[%0d]: got A=%h B=%h av=%b bv=%b lk=%b ec=%0d want A=%h B=%h av=%b bv=%b lk=%b ec=%0d",
                         i, bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt,
                         m_a, m_b, m_av, m_bv, m_lock, exp_errcnt());
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        // First sync locks; each further consecutive sync is a missing-B error.
        for (int i = 0; i < 301; i++) begin
            send(1'b1, 1'b1, W'(i));
            n_cmp++;
            if (bus.ErrCnt !== exp_errcnt()) begin
                n_err++;
                $display("FAIL saturation[%0d]: got ec=%0d want ec=%0d", i, bus.ErrCnt, exp_errcnt());
            end
        end
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 8'd0);
        n_cmp++;
`ifdef TDM_DEMUX2_ERRCNT_EN
        if (bus.ErrCnt !== 8'd255) begin
            n_err++;
            $display("FAIL saturation_hold: got ec=%0d want ec=255", bus.ErrCnt);
        end
`else
        if (bus.ErrCnt !== 8'd0) begin
            n_err++;
            $display("FAIL saturation_hold: got ec=%0d want ec=0", bus.ErrCnt);
        end
`endif
    endtask

    task automatic test_idle_hold();
        apply_reset();
        send(1'b1, 1'b1, 8'hA5);
        send(1'b1, 1'b0, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b1, W'($urandom));
            n_cmp++;
            if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked} !== {8'hA5, 8'h5A, 3'b001}) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got A=%h B=%h av=%b bv=%b lk=%b want A=a5 B=5a av=0 bv=0 lk=1",
                         i, bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked);
            end
        end
    endtask

    task automatic test_midstream_reset();
        apply_reset();
        send(1'b1, 1'b1, 8'h11);
        send(1'b1, 1'b0, 8'h22);
        send(1'b1, 1'b0, 8'h33);
        send(1'b1, 1'b1, 8'h44);
        bus.Valid = 1'b1; bus.Sync = 1'b0; bus.D = 8'h55;
        #1;
        Resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt} !== 27'd0) begin
            n_err++;
            $display("FAIL async_reset: got A=%h B=%h av=%b bv=%b lk=%b ec=%0d want all 0",
                     bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked, bus.ErrCnt);
        end
        @(posedge Clock); #1;
        Resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, W'(8'h60 + i));
            n_cmp++;
            if ({bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked} !== 19'd0) begin
                n_err++;
                $display("FAIL rehunt[%0d]: got A=%h B=%h av=%b bv=%b lk=%b want all 0",
                         i, bus.A, bus.B, bus.AValid, bus.BValid, bus.Locked);
            end
        end
        send(1'b1, 1'b1, 8'h77);
        n_cmp++;
        if ({bus.A, bus.AValid, bus.Locked} !== {8'h77, 2'b11}) begin
            n_err++;
            $display("FAIL relock: got A=%h av=%b lk=%b want A=77 av=1 lk=1",
                     bus.A, bus.AValid, bus.Locked);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_hunt_discard();
        test_missing_b();
        test_sync_loss();
        test_idle_hold();
        test_random();
        test_saturation();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
